// File: rtl/krnl_rtl_trial_a_example_stream_checker.sv
// AXI4-Stream sink that checks one incrementing-number frame per start pulse,
// counting erroneous beats and applying optional periodic backpressure.
module krnl_rtl_trial_a_example_stream_checker #(
  parameter int C_S_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUMBER_BIT_WIDTH   = 32,
  parameter int C_LENGTH_IN_BYTES    = 16384,
  parameter int C_STALL_EVERY        = 0,
  parameter int C_ERR_COUNT_WIDTH    = 16
) (
  input  logic                                aclk,
  input  logic                                ap_rst_n,
  input  logic                                ap_start,
  output logic                                ap_done,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                                s_axis_tlast,
  output logic [C_ERR_COUNT_WIDTH-1:0]        err_count,
  output logic                                first_err_valid,
  output logic [31:0]                         first_err_beat,
  output logic                                pass
);

  localparam int NW        = (C_NUMBER_BIT_WIDTH < C_S_AXIS_TDATA_WIDTH) ? C_NUMBER_BIT_WIDTH : C_S_AXIS_TDATA_WIDTH;
  localparam int L         = C_S_AXIS_TDATA_WIDTH / NW;
  localparam int SB        = (L > 1) ? $clog2(L) : 0;
  localparam int XW        = (NW > 32) ? NW : 32;
  localparam int BPB       = C_S_AXIS_TDATA_WIDTH / 8;
  localparam int NUM_BEATS = (C_LENGTH_IN_BYTES + BPB - 1) / BPB;
  localparam int REM       = C_LENGTH_IN_BYTES % BPB;
  localparam bit STALL_EN  = (C_STALL_EVERY >= 2);
  localparam int SCW       = STALL_EN ? $clog2(C_STALL_EVERY) : 1;

  localparam logic [31:0]                  LAST_BEAT  = 32'(NUM_BEATS - 1);
  localparam logic [BPB-1:0]               KEEP_ALL   = {BPB{1'b1}};
  localparam logic [BPB-1:0]               KEEP_LAST  = (REM == 0) ? KEEP_ALL : (KEEP_ALL >> (BPB - REM));
  localparam logic [SCW-1:0]               STALL_LAST = STALL_EN ? SCW'(C_STALL_EVERY - 1) : {SCW{1'b0}};
  localparam logic [C_ERR_COUNT_WIDTH-1:0] ERR_MAX    = {C_ERR_COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic                           ap_start_r_q, ap_start_r_d;
  logic [31:0]                    beat_q, beat_d;
  logic [SCW-1:0]                 stall_q, stall_d;
  logic                           tready_q, tready_d;
  logic                           done_q, done_d;
  logic [C_ERR_COUNT_WIDTH-1:0]   err_q, err_d;
  logic                           fev_q, fev_d;
  logic [31:0]                    feb_q, feb_d;
  logic                           pass_q, pass_d;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] exp_data_s;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] data_mask_s;
  logic [BPB-1:0]                  exp_keep_s;
  logic                            last_beat_s;
  logic                            beat_err_s;
  logic                            go_s;
  logic                            hs_s;

  // Expected beat content and per-beat fault detection; data is only compared under expected keep.
  always_comb begin
    exp_data_s  = '0;
    data_mask_s = '0;
    last_beat_s = (beat_q == LAST_BEAT);
    exp_keep_s  = last_beat_s ? KEEP_LAST : KEEP_ALL;
    for (int k = 0; k < L; k++) begin
      exp_data_s[k*NW +: NW] = NW'((XW'(beat_q) << SB) | XW'(k));
    end
    for (int j = 0; j < BPB; j++) begin
      data_mask_s[j*8 +: 8] = {8{exp_keep_s[j]}};
    end
    beat_err_s = (|((s_axis_tdata ^ exp_data_s) & data_mask_s)) ||
                 (s_axis_tkeep != exp_keep_s) ||
                 (s_axis_tlast != last_beat_s);
    go_s = ap_start & ~ap_start_r_q;
    hs_s = s_axis_tvalid & tready_q;
  end

  // Next-state logic for the IDLE/RUN/DONE controller and its status registers.
  always_comb begin
    state_d      = state_q;
    ap_start_r_d = ap_start;
    beat_d       = beat_q;
    stall_d      = stall_q;
    done_d       = 1'b0;
    err_d        = err_q;
    fev_d        = fev_q;
    feb_d        = feb_q;
    pass_d       = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_s) begin
          state_d = S_RUN;
          beat_d  = 32'd0;
          stall_d = {SCW{1'b0}};
          err_d   = {C_ERR_COUNT_WIDTH{1'b0}};
          fev_d   = 1'b0;
          feb_d   = 32'd0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (STALL_EN) begin
          stall_d = (stall_q == STALL_LAST) ? {SCW{1'b0}} : stall_q + SCW'(1);
        end else begin
          stall_d = {SCW{1'b0}};
        end
        if (hs_s) begin
          beat_d = beat_q + 32'd1;
          if (beat_err_s) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + C_ERR_COUNT_WIDTH'(1);
            if (!fev_q) begin
              fev_d = 1'b1;
              feb_d = beat_q;
            end else begin
              fev_d = fev_q;
            end
          end else begin
            err_d = err_q;
          end
          // A stray or missing tlast both close the frame here.
          if (s_axis_tlast || last_beat_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_d == {C_ERR_COUNT_WIDTH{1'b0}});
          end else begin
            state_d = S_RUN;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    tready_d = (state_d == S_RUN) && !(STALL_EN && (stall_d == STALL_LAST));
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!ap_rst_n) begin
      state_q      <= S_IDLE;
      ap_start_r_q <= 1'b0;
      beat_q       <= 32'd0;
      stall_q      <= {SCW{1'b0}};
      tready_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= {C_ERR_COUNT_WIDTH{1'b0}};
      fev_q        <= 1'b0;
      feb_q        <= 32'd0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ap_start_r_q <= ap_start_r_d;
      beat_q       <= beat_d;
      stall_q      <= stall_d;
      tready_q     <= tready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fev_q        <= fev_d;
      feb_q        <= feb_d;
      pass_q       <= pass_d;
    end
  end

  assign ap_done         = done_q;
  assign s_axis_tready   = tready_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_beat  = feb_q;
  assign pass            = pass_q;

endmodule

// File: doc/krnl_rtl_trial_a_example_stream_checker.md
# krnl_rtl_trial_a_example_stream_checker

AXI4-Stream sink that sits directly downstream of the example number generator and checks its output on the fly. On each start it accepts exactly one frame, compares every beat against the expected incrementing-number pattern, expected TKEEP and expected TLAST position, and records error statistics. It then signals done. It applies optional deterministic backpressure so the producer's stall handling is exercised in-system.

## Interface
- C_S_AXIS_TDATA_WIDTH, 128: stream width in bits; a multiple of C_NUMBER_BIT_WIDTH, or smaller than it.
- C_NUMBER_BIT_WIDTH, 32: width of one number lane.
- C_LENGTH_IN_BYTES, 16384: frame length in bytes.
- C_STALL_EVERY, 0: 0 means tready is always high in RUN. N≥2 means tready is dropped for 1 cycle out of every N RUN cycles.
- C_ERR_COUNT_WIDTH, 16: error counter width.
- aclk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- ap_start  in  1  level; its rising edge starts a check.
- ap_done  out  1  one-cycle pulse at end of frame.
- s_axis_tvalid  in  1  producer valid.
- s_axis_tready  out  1  checker ready.
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  data.
- s_axis_tkeep  in  C_S_AXIS_TDATA_WIDTH/8  byte enables.
- s_axis_tlast  in  1  end of frame.
- err_count  out  C_ERR_COUNT_WIDTH  number of erroneous beats, saturating.
- first_err_valid  out  1  at least one error has occurred.
- first_err_beat  out  32  beat index of the first error.
- pass  out  1  high in DONE when err_count==0.

## Operation
- Derived values follow the generator's arithmetic:
  - NW = min(C_NUMBER_BIT_WIDTH, C_S_AXIS_TDATA_WIDTH)
  - L = C_S_AXIS_TDATA_WIDTH/NW
  - SB = L>1 ? clog2(L) : 0
  - NUM_BEATS = ceil(C_LENGTH_IN_BYTES/(C_S_AXIS_TDATA_WIDTH/8))
  - Expected lane k of beat b = ((b << SB) | k) mod 2^NW.
- Expected tkeep is all ones, except on the final beat when the length is not a whole number of beats. In that case it is (1 << (C_LENGTH_IN_BYTES mod bytes_per_beat)) − 1.
- The checker tracks ap_start_r, a register holding ap_start from the previous cycle. go = ap_start & ~ap_start_r.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on go. Entering RUN clears the beat counter, err_count, first_err_*, the stall counter and pass.
  - RUN→DONE on a handshake (tvalid&tready) where tlast==1 or beat==NUM_BEATS−1.
  - DONE→RUN on go. go is ignored while in RUN.
- s_axis_tready = (state==RUN) && !(C_STALL_EVERY≥2 && stall_cnt==C_STALL_EVERY−1).
  - stall_cnt increments every RUN cycle and wraps to 0 at C_STALL_EVERY−1.
  - tready never depends on tvalid.
- A beat is erroneous if any of the following holds (one increment per beat, however many faults):
  - tdata differs from expected on any byte where expected tkeep is 1;
  - tkeep differs from expected tkeep;
  - tlast differs from (beat==NUM_BEATS−1).
- Early tlast counts as an error and terminates the frame. A missing tlast on beat NUM_BEATS−1 counts as an error and terminates the frame.
- err_count saturates at 2^C_ERR_COUNT_WIDTH−1.
- first_err_beat is captured on the first erroneous beat only.
- Beat counter is 32 bits wide and increments per handshake.

## Timing
- Reset values: ap_done=0, s_axis_tready=0, err_count=0, first_err_valid=0, first_err_beat=0, pass=0. State is IDLE and ap_start_r=0.
- ap_rst_n low in any state forces the reset values on the next edge, aborting a frame in progress. After reset, a level-high ap_start starts a check one cycle after ap_rst_n rises, because ap_start_r resets to 0.
- Start: go seen at edge T, so state is RUN and tready=1 from T+1. The first beat can be accepted at T+1.
- Compare is single-cycle. Status registers update at the edge that completes the handshake.
- Final handshake at edge F gives state DONE, ap_done=1, and final status/pass during cycle F+1. ap_done is high for exactly one cycle.
- Status outputs hold through DONE until the next go or reset.
- Throughput is 1 beat/cycle when C_STALL_EVERY=0. It is (N−1)/N otherwise.

## Test plan
- Defaults, compliant 1024-beat frame, tvalid always high:
  - beat 0 = {3,2,1,0}, beat 1 = {7,6,5,4};
  - expect ap_done 1 cycle after beat 1023, err_count=0, pass=1, first_err_valid=0.
- Defaults, lane 2 of beat 10 corrupted:
  - expect err_count=1, first_err_beat=10, pass=0.
- C_LENGTH_IN_BYTES=20:
  - 2 beats, final tkeep=0x000F, garbage in masked bytes → pass=1;
  - final tkeep=0xFFFF → err_count=1, first_err_beat=1.
- Defaults, tlast asserted on beat 5:
  - expect DONE after beat 5, err_count=1, first_err_beat=5, ap_done at the following cycle.
- C_STALL_EVERY=4, producer tvalid random:
  - tready low on every 4th RUN cycle;
  - no beat lost or duplicated, err_count=0.
- Reset mid-frame at beat 100:
  - all outputs return to reset values;
  - a new go then checks a fresh frame from beat 0 with pass=1;
  - a second go during RUN is ignored.
